// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
//   rf_state_e   : clear sequencer states (IDLE, CLEAR)
//   RF_ZERO_ADDR : index of the hardwired-zero register
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int unsigned RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, marking destinations still in flight.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en, set_addr    mark a destination busy (issue)
//   clr_en, clr_addr    per write port: clear the busy bit of a written register
//   wipe_en, wipe_addr  clear sequencer: clear one busy bit per cycle
//   busy                current busy vector (bit 0 always 0)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int NUM_WR = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_en,
    input  logic [AW-1:0]              set_addr,
    input  logic [NUM_WR-1:0]          clr_en,
    input  logic [NUM_WR-1:0][AW-1:0]  clr_addr,
    input  logic                       wipe_en,
    input  logic [AW-1:0]              wipe_addr,
    output logic [DEPTH-1:0]           busy
);

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (clr_en[p]) busy_d[clr_addr[p]] = 1'b0;
        end
        if (wipe_en) busy_d[wipe_addr] = 1'b0;
        // Set applied last so a same-cycle issue beats the writeback clear.
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[RF_ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with clear sequencer and busy scoreboard.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_rs_addr/o_rs_data NUM_RD combinational read ports
//   o_rs_busy           scoreboard busy bit for each read address
//   i_wr_en/addr/data   NUM_WR write ports (highest-numbered port wins on conflict)
//   i_issue_valid/addr  mark a destination register busy
//   i_clr_req           start a sequential clear of the whole file
//   o_ready             high while IDLE (writes/issues accepted)
//   o_clr_done          one-cycle pulse when a clear finishes
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_RD-1:0][AW-1:0]    i_rs_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]  o_rs_data,
    output logic [NUM_RD-1:0]            o_rs_busy,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    i_wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]  i_wr_data,
    input  logic                         i_issue_valid,
    input  logic [AW-1:0]                i_issue_addr,
    input  logic                         i_clr_req,
    output logic                         o_ready,
    output logic                         o_clr_done
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             clr_done_q, clr_done_d;
    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [NUM_WR-1:0] wr_acc;
    logic             idle;

    assign idle = (state_q == IDLE);

    // A write is accepted only in IDLE and never to the zero register.
    always_comb begin
        wr_acc = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_acc[p] = i_wr_en[p] && idle && (i_wr_addr[p] != AW'(RF_ZERO_ADDR));
        end
    end

    // Clear sequencer: entry 0 is already zero, so the sweep runs 1..DEPTH-1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Ascending port order: the last non-blocking update (highest port) wins.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_acc[p]) regs_q[i_wr_addr[p]] <= i_wr_data[p];
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .set_en    (i_issue_valid && idle),
        .set_addr  (i_issue_addr),
        .clr_en    (wr_acc),
        .clr_addr  (i_wr_addr),
        .wipe_en   (state_q == CLEAR),
        .wipe_addr (cnt_q),
        .busy      (busy)
    );

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            if (i_rs_addr[k] == AW'(RF_ZERO_ADDR)) begin
                o_rs_data[k] = '0;
            end else begin
                o_rs_data[k] = regs_q[i_rs_addr[k]];
            end
            o_rs_busy[k] = busy[i_rs_addr[k]];
`ifdef REGFILE_BYPASS_EN
            // wr_acc already excludes address 0 and the CLEAR state.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_acc[p] && (i_wr_addr[p] == i_rs_addr[k])) begin
                    o_rs_data[k] = i_wr_data[p];
                    o_rs_busy[k] = 1'b0;
                end
            end
`endif
        end
    end

    assign o_ready    = idle;
    assign o_clr_done = clr_done_q;

endmodule
